blink_write_arbiter: RTL and testbench



---
 rtl/blink_pkg.sv | 13 +
 rtl/blink_write_arbiter_rr_pick.sv | 25 ++
 rtl/blink_write_arbiter.sv | 152 +++++++++++++++
 tb/tb_blink_write_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared types and defaults for the LED blinker write path.
package blink_pkg;

    localparam int unsigned CHAR_W              = 8;
    localparam int unsigned FIFO_DEPTH_DEFAULT  = 256;
    localparam int unsigned CHAR_CYCLES_DEFAULT = 100000000;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

endpackage

// File: rtl/blink_write_arbiter_rr_pick.sv
// Round-robin priority select: first asserted request after index `last`, wrapping.
module rr_pick #(
    parameter int unsigned N   = 2,
    parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [IDW-1:0] winner,
    output logic           any
);

    // Scan from farthest to nearest so the nearest asserted request overwrites the rest.
    always_comb begin
        winner = '0;
        any    = |req;
        for (int k = int'(N); k >= 1; k--) begin
            for (int j = 0; j < int'(N); j++) begin
                if (req[j] && (j == ((int'(last) + k) % int'(N)))) begin
                    winner = IDW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/blink_write_arbiter.sv
// Per-message arbiter for the blinker byte port with drain-rate flow control.
// Optional macro GRANT_TIMEOUT_EN adds a forced release of an idle grant and timeout_flag.
module blink_write_arbiter
    import blink_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned CHAR_CYCLES = CHAR_CYCLES_DEFAULT,
    parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEFAULT
`ifdef GRANT_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*CHAR_W-1:0]     req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [CHAR_W-1:0]             blk_data,
    output logic                          blk_enable,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy
`ifdef GRANT_TIMEOUT_EN
    ,
    output logic                          timeout_flag
`endif
);

    localparam int unsigned IDW    = $clog2(NUM_REQ);
    localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TICK_W = (CHAR_CYCLES > 1) ? $clog2(CHAR_CYCLES) : 1;
    localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(FIFO_DEPTH - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CHAR_CYCLES - 1);

    arb_state_t         state, state_next;
    logic [IDW-1:0]     last_grant;
    logic [TICK_W-1:0]  tick;
    logic [IDW-1:0]     pick_id;
    logic               pick_any;
    logic               drain, dec, can_accept;
    logic               grant_valid, grant_last, hs, release_grant, expire;
    logic [CHAR_W-1:0]  grant_byte;

    rr_pick #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_pick (
        .req    (req_valid),
        .last   (last_grant),
        .winner (pick_id),
        .any    (pick_any)
    );

    assign drain       = (tick == TICK_LAST);
    assign dec         = drain && (occupancy != '0);
    assign can_accept  = (occupancy < OCC_FULL);
    assign grant_valid = req_valid[grant_id];
    assign grant_last  = req_last[grant_id];
    assign grant_byte  = req_data[CHAR_W*grant_id +: CHAR_W];

`ifdef GRANT_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] to_cnt;

    assign expire = (state == ARB_GRANT) && !grant_valid && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Idle-valid counter; cleared by any byte or any exit from GRANT.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state != ARB_GRANT || hs || expire) begin
                to_cnt <= '0;
            end else if (!grant_valid) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (expire) begin
                timeout_flag <= 1'b1;
            end
        end
    end
`else
    assign expire = 1'b0;
`endif

    assign release_grant = (hs && grant_last) || expire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ready is only ever offered to the locked requester, and only with room downstream.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        hs         = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_any && can_accept) begin
                    state_next = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                req_ready[grant_id] = can_accept;
                hs                  = grant_valid && can_accept;
                if (release_grant) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick       <= '0;
            blk_data   <= '0;
            blk_enable <= 1'b0;
            grant_id   <= '0;
            last_grant <= IDW'(NUM_REQ - 1);
            busy       <= 1'b0;
            occupancy  <= '0;
        end else begin
            tick       <= drain ? '0 : tick + TICK_W'(1);
            blk_enable <= hs;
            busy       <= (state_next == ARB_GRANT);
            if (hs) begin
                blk_data <= grant_byte;
            end
            if (state == ARB_IDLE && state_next == ARB_GRANT) begin
                grant_id <= pick_id;
            end
            if (release_grant) begin
                last_grant <= grant_id;
            end
            // Mirror of the blinker queue: accept and drain in one cycle cancel out.
            if (hs && !dec) begin
                occupancy <= occupancy + OCC_W'(1);
            end else if (!hs && dec) begin
                occupancy <= occupancy - OCC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_blink_write_arbiter.sv
// Scoreboard bench for blink_write_arbiter with short character period and small buffer.
module tb_blink_write_arbiter;

    localparam int unsigned NUM_REQ     = 2;
    localparam int unsigned CHAR_CYCLES = 4;
    localparam int unsigned FIFO_DEPTH  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        v0, v1, l0, l1;
    logic [7:0]  d0, d1;
    logic [1:0]  req_valid, req_last, req_ready;
    logic [15:0] req_data;
    logic [7:0]  blk_data;
    logic        blk_enable;
    logic [0:0]  grant_id;
    logic        busy;
    logic [3:0]  occupancy;
`ifdef GRANT_TIMEOUT_EN
    logic        timeout_flag;
`endif

    assign req_valid = {v1, v0};
    assign req_last  = {l1, l0};
    assign req_data  = {d1, d0};

    blink_write_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .CHAR_CYCLES    (CHAR_CYCLES),
        .FIFO_DEPTH     (FIFO_DEPTH)
`ifdef GRANT_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .blk_data   (blk_data),
        .blk_enable (blk_enable),
        .grant_id   (grant_id),
        .busy       (busy),
        .occupancy  (occupancy)
`ifdef GRANT_TIMEOUT_EN
        ,
        .timeout_flag (timeout_flag)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    int          checks   = 0;
    int          failures = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  mon_exp;
    int          max_occ = 0;
    int          full_ready_viol = 0;

    // Monitor: every byte pulse to the blinker must match the next expected {source, byte}.
    always @(negedge clk) begin
        if (blk_enable) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_extra actual id=%0d data=%02h required none", grant_id, blk_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({grant_id, blk_data} !== mon_exp) begin
                    failures++;
                    $display("FAIL scoreboard_byte actual id=%0d data=%02h required id=%0d data=%02h",
                             grant_id, blk_data, mon_exp[8], mon_exp[7:0]);
                end
            end
        end
        if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
        if (occupancy == 4'd7 && req_ready != 2'b00) full_ready_viol++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic set_req(input int r, input logic v, input logic [7:0] d, input logic l);
        if (r == 0) begin
            v0 = v; d0 = d; l0 = l;
        end else begin
            v1 = v; d1 = d; l1 = l;
        end
    endtask

    task automatic push_exp(input logic id, input logic [7:0] d);
        exp_q.push_back({id, d});
    endtask

    // Present one byte and hold it until the handshake edge; returns that edge's cycle index.
    task automatic send(input int r, input logic [7:0] d, input logic l, output int hc);
        set_req(r, 1'b1, d, l);
        hc = -1;
        for (int g = 0; g < 200 && hc < 0; g++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                @(posedge clk);
                #1;
                hc = cyc;
            end
        end
        if (hc < 0) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout req=%0d data=%02h actual=none required=handshake", r, d);
        end
    endtask

    task automatic send_msg(input int r, input logic [7:0] base, input int n);
        int hc;
        for (int k = 0; k < n; k++) begin
            send(r, base + 8'(k), (k == n - 1), hc);
        end
    endtask

    task automatic wait_neg(input int n);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (cyc < n && g < 1000);
        if (cyc != n) begin
            checks++;
            failures++;
            $display("FAIL wait_cycle actual=%0d required=%0d", cyc, n);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_req(0, 1'b0, 8'h00, 1'b0);
        set_req(1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int hc;
        int hcs[10];

        // Reset values
        do_reset();
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_blk_enable", int'(blk_enable), 0);
        check("rst_blk_data", int'(blk_data), 0);
        check("rst_grant_id", int'(grant_id), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_occupancy", int'(occupancy), 0);

        // Single two-byte message from requester 0
        push_exp(1'b0, 8'h41);
        push_exp(1'b0, 8'h42);
        set_req(0, 1'b1, 8'h41, 1'b0);
        @(negedge clk);
        check("t1_ready_during_arb", int'(req_ready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_ready_granted", int'(req_ready), 1);
        check("t1_busy_granted", int'(busy), 1);
        @(posedge clk); #1;
        set_req(0, 1'b1, 8'h42, 1'b1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("t1_busy_after_last", int'(busy), 0);
        check("t1_occ_two", int'(occupancy), 2);
        wait_neg(4);
        check("t1_occ_after_drain", int'(occupancy), 1);
        repeat (2) @(posedge clk);

        // Contention: req0 message, req1 message, then req0 again (round robin)
        do_reset();
        for (int k = 0; k < 3; k++) push_exp(1'b0, 8'hA1 + 8'(k));
        for (int k = 0; k < 3; k++) push_exp(1'b1, 8'hB1 + 8'(k));
        for (int k = 0; k < 3; k++) push_exp(1'b0, 8'hC1 + 8'(k));
        fork
            begin
                send_msg(0, 8'hA1, 3);
                send_msg(0, 8'hC1, 3);
                set_req(0, 1'b0, 8'h00, 1'b0);
            end
            begin
                send_msg(1, 8'hB1, 3);
                set_req(1, 1'b0, 8'h00, 1'b0);
            end
        join
        wait_neg(12);
        check("t2_occ_end", int'(occupancy), 6);
        repeat (2) @(posedge clk);

        // Full throttle: ten bytes into a 7-entry usable buffer
        do_reset();
        for (int k = 0; k < 10; k++) push_exp(1'b0, 8'h30 + 8'(k));
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    send(0, 8'h30 + 8'(k), (k == 9), hc);
                    hcs[k] = hc;
                end
                set_req(0, 1'b0, 8'h00, 1'b0);
            end
            begin
                wait_neg(10);
                check("t3_ready_full_a", int'(req_ready), 0);
                check("t3_occ_full", int'(occupancy), 7);
                wait_neg(11);
                check("t3_ready_full_b", int'(req_ready), 0);
            end
        join
        check("t3_hs_cycle_b1", hcs[0], 2);
        check("t3_hs_cycle_b9", hcs[8], 10);
        check("t3_hs_cycle_b10", hcs[9], 13);
        wait_neg(13);
        check("t3_occ_final", int'(occupancy), 7);
        repeat (2) @(posedge clk);

        // Drain and accept on the same edge at occupancy 3
        do_reset();
        wait_neg(4);
        check("t4_empty_drain_a", int'(occupancy), 0);
        do begin
            @(posedge clk); #1;
        end while (cyc < 7);
        for (int k = 0; k < 4; k++) push_exp(1'b0, 8'hD1 + 8'(k));
        fork
            begin
                send_msg(0, 8'hD1, 4);
                set_req(0, 1'b0, 8'h00, 1'b0);
            end
            begin
                wait_neg(8);
                check("t4_empty_drain_b", int'(occupancy), 0);
                wait_neg(11);
                check("t4_occ_before", int'(occupancy), 3);
                wait_neg(12);
                check("t4_occ_coincident", int'(occupancy), 3);
            end
        join
        repeat (2) @(posedge clk);

        // Reset in the middle of a message, after req0 had already been served once
        do_reset();
        push_exp(1'b0, 8'h58);
        send(0, 8'h58, 1'b1, hc);
        push_exp(1'b0, 8'h61);
        send(0, 8'h61, 1'b0, hc);
        set_req(0, 1'b1, 8'h62, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("t5_req_ready", int'(req_ready), 0);
        check("t5_blk_enable", int'(blk_enable), 0);
        check("t5_blk_data", int'(blk_data), 0);
        check("t5_grant_id", int'(grant_id), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_occupancy", int'(occupancy), 0);
        reset = 1'b0;
        push_exp(1'b0, 8'h71);
        push_exp(1'b1, 8'h81);
        fork
            begin
                int h0;
                send(0, 8'h71, 1'b1, h0);
                set_req(0, 1'b0, 8'h00, 1'b0);
            end
            begin
                int h1;
                send(1, 8'h81, 1'b1, h1);
                set_req(1, 1'b0, 8'h00, 1'b0);
            end
        join
        repeat (2) @(posedge clk);

`ifdef GRANT_TIMEOUT_EN
        // Granted requester goes silent mid-message; pending req1 takes over after the timeout
        do_reset();
        push_exp(1'b0, 8'h53);
        push_exp(1'b1, 8'h54);
        fork
            begin
                int h0;
                send(0, 8'h53, 1'b0, h0);
                set_req(0, 1'b0, 8'h00, 1'b0);
            end
            begin
                int h1;
                send(1, 8'h54, 1'b1, h1);
                set_req(1, 1'b0, 8'h00, 1'b0);
            end
            begin
                wait_neg(9);
                check("t6_busy_before", int'(busy), 1);
                check("t6_flag_before", int'(timeout_flag), 0);
                wait_neg(10);
                check("t6_busy_after", int'(busy), 0);
                check("t6_flag_after", int'(timeout_flag), 1);
            end
        join
        repeat (2) @(posedge clk);
`endif

        repeat (2) @(posedge clk);
        check("sb_queue_empty", exp_q.size(), 0);
        check("full_ready_violations", full_ready_viol, 0);
        check("max_occ_within_cap", int'(max_occ <= 7), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
